// File: rtl/dma_pkg.sv
// Constants shared by the DMA engine and its data FIFO so both agree on
// word width, burst length and buffer depth.
package dma_pkg;

    localparam int unsigned DMA_DATA_WIDTH  = 32;
    localparam int unsigned DMA_BURST_LEN   = 8;
    localparam int unsigned DMA_FIFO_ADDR_W = 5;

    typedef logic [DMA_DATA_WIDTH-1:0] dma_word_t;

endpackage

// File: rtl/dma_data_fifo_if.sv
// Push/pop, status and error-flag signals between the DMA engine (master)
// and its data FIFO (slave).
interface dma_data_fifo_if
    import dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int unsigned ADDR_W     = DMA_FIFO_ADDR_W
) ();

    logic                  fifo_wen;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_rden;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_is_empty;
    logic                  fifo_is_full;
    logic [ADDR_W:0]       fifo_count;
    logic                  burst_space;
    logic                  err_clr;
    logic                  err_ovf;
    logic                  err_udf;

    modport master (
        output fifo_wen, fifo_wdata, fifo_rden, err_clr,
        input  fifo_rdata, fifo_is_empty, fifo_is_full, fifo_count, burst_space,
               err_ovf, err_udf
    );

    modport slave (
        input  fifo_wen, fifo_wdata, fifo_rden, err_clr,
        output fifo_rdata, fifo_is_empty, fifo_is_full, fifo_count, burst_space,
               err_ovf, err_udf
    );

endinterface

// File: rtl/dma_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module dma_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_data_fifo.sv
// First-word-fall-through data FIFO between the DMA read and write paths,
// with occupancy, burst-space indication and sticky overflow/underflow flags.
module dma_data_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int unsigned ADDR_W     = DMA_FIFO_ADDR_W,
    parameter int unsigned BURST_LEN  = DMA_BURST_LEN
) (
    input logic            clk,
    input logic            rst,
    dma_data_fifo_if.slave fifo
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // burst_space holds while count leaves at least one whole burst free
    localparam logic [ADDR_W:0] SPACE_MAX = (ADDR_W + 1)'(DEPTH - BURST_LEN);

    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W:0]       count;
    logic                  empty;
    logic                  full;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ovf_set;
    logic                  udf_set;
    logic                  err_ovf;
    logic                  err_udf;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign count = wr_ptr - rd_ptr;

    // A pop frees the full slot in the same cycle, so push-while-full is legal with rden
    assign push_ok = fifo.fifo_wen && (!full || fifo.fifo_rden);
    assign pop_ok  = fifo.fifo_rden && !empty;
    assign ovf_set = fifo.fifo_wen && full && !fifo.fifo_rden;
    assign udf_set = fifo.fifo_rden && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A new error event outranks a concurrent clear
            err_ovf <= (err_ovf && !fifo.err_clr) || ovf_set;
            err_udf <= (err_udf && !fifo.err_clr) || udf_set;
        end
    end

    dma_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (fifo.fifo_wdata),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    assign fifo.fifo_rdata    = empty ? '0 : ram_rdata;
    assign fifo.fifo_is_empty = empty;
    assign fifo.fifo_is_full  = full;
    assign fifo.fifo_count    = count;
    assign fifo.burst_space   = (count <= SPACE_MAX);
    assign fifo.err_ovf       = err_ovf;
    assign fifo.err_udf       = err_udf;

endmodule

// File: tb/tb_dma_data_fifo.sv
// Directed self-checking bench for dma_data_fifo: fill/drain, full and empty
// corner cases, sticky errors, streaming across pointer wrap, and reset.
module tb_dma_data_fifo;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dma_data_fifo_if #(.DATA_WIDTH(32), .ADDR_W(5)) bus ();

    dma_data_fifo dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bus.fifo_wen   = 1'b1;
        bus.fifo_wdata = d;
        step();
        bus.fifo_wen   = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check(tag, 64'(bus.fifo_rdata), 64'(exp));
        bus.fifo_rden = 1'b1;
        step();
        bus.fifo_rden = 1'b0;
    endtask

    task automatic clear_errors();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.fifo_wen   = 1'b0;
        bus.fifo_wdata = '0;
        bus.fifo_rden  = 1'b0;
        bus.err_clr    = 1'b0;
        step();
        step();
        rst = 1'b0;

        // 1. Reset state and first eight pushes
        check("rst_count", 64'(bus.fifo_count), 64'd0);
        check("rst_empty", 64'(bus.fifo_is_empty), 64'd1);
        check("rst_full", 64'(bus.fifo_is_full), 64'd0);
        check("rst_bspace", 64'(bus.burst_space), 64'd1);
        check("rst_rdata", 64'(bus.fifo_rdata), 64'd0);
        check("rst_errs", 64'({bus.err_ovf, bus.err_udf}), 64'd0);
        push(32'h100);
        check("fwft_first", 64'(bus.fifo_rdata), 64'h100);
        check("fwft_count", 64'(bus.fifo_count), 64'd1);
        for (int i = 1; i < 8; i++) push(32'h100 + 32'(i));
        check("t1_count", 64'(bus.fifo_count), 64'd8);
        check("t1_bspace", 64'(bus.burst_space), 64'd1);
        for (int i = 0; i < 8; i++) pop_check("t1_data", 32'h100 + 32'(i));
        check("t1_empty", 64'(bus.fifo_is_empty), 64'd1);

        // 2. Fill to full, overflow, drain in order
        for (int i = 0; i < 32; i++) begin
            push(32'h200 + 32'(i));
            if (i == 23) check("bspace_at24", 64'(bus.burst_space), 64'd1);
            if (i == 24) check("bspace_at25", 64'(bus.burst_space), 64'd0);
        end
        check("t2_full", 64'(bus.fifo_is_full), 64'd1);
        check("t2_count", 64'(bus.fifo_count), 64'd32);
        check("t2_bspace", 64'(bus.burst_space), 64'd0);
        check("t2_no_ovf", 64'(bus.err_ovf), 64'd0);
        push(32'hDEAD);
        check("t2_ovf", 64'(bus.err_ovf), 64'd1);
        check("t2_ovf_count", 64'(bus.fifo_count), 64'd32);
        for (int i = 0; i < 32; i++) pop_check("t2_data", 32'h200 + 32'(i));
        check("t2_empty", 64'(bus.fifo_is_empty), 64'd1);
        check("t2_count0", 64'(bus.fifo_count), 64'd0);
        check("t2_ovf_sticky", 64'(bus.err_ovf), 64'd1);
        clear_errors();
        check("t2_ovf_clr", 64'(bus.err_ovf), 64'd0);

        // 3. Full with simultaneous push and pop
        for (int i = 0; i < 32; i++) push(32'h300 + 32'(i));
        check("t3_head", 64'(bus.fifo_rdata), 64'h300);
        bus.fifo_wen   = 1'b1;
        bus.fifo_wdata = 32'h3AA;
        bus.fifo_rden  = 1'b1;
        step();
        bus.fifo_wen  = 1'b0;
        bus.fifo_rden = 1'b0;
        check("t3_count", 64'(bus.fifo_count), 64'd32);
        check("t3_full", 64'(bus.fifo_is_full), 64'd1);
        check("t3_no_ovf", 64'(bus.err_ovf), 64'd0);
        for (int i = 1; i < 32; i++) pop_check("t3_data", 32'h300 + 32'(i));
        pop_check("t3_tail", 32'h3AA);
        check("t3_empty", 64'(bus.fifo_is_empty), 64'd1);

        // 4. Empty with simultaneous push and pop, underflow, set-beats-clear
        bus.fifo_wen   = 1'b1;
        bus.fifo_wdata = 32'hA5;
        bus.fifo_rden  = 1'b1;
        step();
        bus.fifo_wen  = 1'b0;
        bus.fifo_rden = 1'b0;
        check("t4_udf", 64'(bus.err_udf), 64'd1);
        check("t4_count", 64'(bus.fifo_count), 64'd1);
        check("t4_rdata", 64'(bus.fifo_rdata), 64'hA5);
        clear_errors();
        check("t4_clr", 64'({bus.err_ovf, bus.err_udf}), 64'd0);
        pop_check("t4_pop", 32'hA5);
        bus.fifo_rden = 1'b1;
        bus.err_clr   = 1'b1;
        step();
        bus.fifo_rden = 1'b0;
        bus.err_clr   = 1'b0;
        check("t4_set_wins", 64'(bus.err_udf), 64'd1);
        check("t4_udf_count", 64'(bus.fifo_count), 64'd0);
        clear_errors();
        check("t4_clr2", 64'(bus.err_udf), 64'd0);

        // 5. Streaming across several pointer wraps
        push(32'h1000);
        bus.fifo_wen  = 1'b1;
        bus.fifo_rden = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.fifo_wdata = 32'h1001 + 32'(i);
            check("t5_data", 64'(bus.fifo_rdata), 64'h1000 + 64'(i));
            step();
            check("t5_count", 64'(bus.fifo_count), 64'd1);
        end
        bus.fifo_wen  = 1'b0;
        bus.fifo_rden = 1'b0;
        pop_check("t5_last", 32'h1064);
        check("t5_empty", 64'(bus.fifo_is_empty), 64'd1);
        check("t5_errs", 64'({bus.err_ovf, bus.err_udf}), 64'd0);

        // 6. Reset mid-operation
        bus.fifo_rden = 1'b1;
        step();
        bus.fifo_rden = 1'b0;
        check("t6_udf_pre", 64'(bus.err_udf), 64'd1);
        for (int i = 0; i < 20; i++) push(32'h500 + 32'(i));
        check("t6_count20", 64'(bus.fifo_count), 64'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_count", 64'(bus.fifo_count), 64'd0);
        check("t6_empty", 64'(bus.fifo_is_empty), 64'd1);
        check("t6_rdata", 64'(bus.fifo_rdata), 64'd0);
        check("t6_errs", 64'({bus.err_ovf, bus.err_udf}), 64'd0);
        push(32'h77);
        check("t6_push", 64'(bus.fifo_rdata), 64'h77);
        check("t6_push_count", 64'(bus.fifo_count), 64'd1);
        pop_check("t6_pop", 32'h77);
        check("t6_empty2", 64'(bus.fifo_is_empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
